// File: rtl/rx_resp_tracker_pkg.sv
// Shared types and helpers for the rx_resp_tracker response path.
// The resp_t field widths and the channel index width are fixed by the package defaults.
package rx_pkg;

  localparam int NUM_SW_INST_D = 5;
  localparam int W_WIDTH_D     = 8;
  localparam int OP_W_D        = 8;
  localparam int DEPTH_D       = 2;

  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int CH_W = ch_w(NUM_SW_INST_D);

  typedef struct packed {
    logic [W_WIDTH_D-1:0] data;
    logic [OP_W_D-1:0]    op_id;
    logic [CH_W-1:0]      ch;
  } resp_t;

  // Round-robin successor: one past the granted channel, wrapping at n.
  function automatic logic [CH_W-1:0] rr_next(input logic [CH_W-1:0] cur, input int n);
    int nx;
    nx = int'(cur) + 1;
    if (nx >= n) nx = 0;
    return nx[CH_W-1:0];
  endfunction

endpackage

// File: rtl/rx_op_fifo.sv
// Per-channel FIFO of outstanding op_ids; the caller guarantees push/pop legality.
module rx_op_fifo #(
  parameter int OP_W  = 8,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [OP_W-1:0]          din,
  input  logic                     pop,
  output logic [OP_W-1:0]          dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [OP_W-1:0] mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      cnt <= cnt + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  assign dout  = mem[rd_ptr];
  assign full  = (cnt == CW'(DEPTH));
  assign empty = (cnt == '0);
  assign count = cnt;

endmodule

// File: rtl/rx_resp_tracker.sv
// Tracks outstanding ops per switch, pairs acks with the oldest op and merges
// completed responses onto one round-robin valid/ready stream.
module rx_resp_tracker
  import rx_pkg::*;
#(
  parameter int NUM_SW_INST = NUM_SW_INST_D,
  parameter int W_WIDTH     = W_WIDTH_D,
  parameter int OP_W        = OP_W_D,
  parameter int DEPTH       = DEPTH_D
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_SW_INST-1:0]         sel_en,
  input  logic [OP_W-1:0]                op_id,
  input  logic [NUM_SW_INST-1:0]         ack,
  input  logic [NUM_SW_INST*W_WIDTH-1:0] rd_data,
  input  logic                           resp_ready,
  input  logic                           err_clr,
  output logic [NUM_SW_INST-1:0]         sw_busy,
  output logic                           resp_valid,
  output logic [W_WIDTH-1:0]             rd_data_out,
  output logic [OP_W-1:0]                op_id_out,
  output logic [CH_W-1:0]                resp_ch,
  output logic [NUM_SW_INST-1:0]         err_ovf,
  output logic [NUM_SW_INST-1:0]         err_unexp
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [NUM_SW_INST-1:0] full, empty, push_ok, pop, drain, hold_nxt, busy_nxt;
  logic [NUM_SW_INST-1:0] vld_p0;
  logic [OP_W-1:0]        head [NUM_SW_INST];
  logic [CW-1:0]          cnt  [NUM_SW_INST];
  resp_t                  hold_p0 [NUM_SW_INST];
  resp_t                  out_p1;
  logic                   vld_p1;
  logic [CH_W-1:0]        rr_ptr, gnt;
  logic                   gnt_vld;

  for (genvar g = 0; g < NUM_SW_INST; g++) begin : g_ch
    logic [CW-1:0] cnt_nxt;

    rx_op_fifo #(.OP_W(OP_W), .DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push_ok[g]),
      .din   (op_id),
      .pop   (pop[g]),
      .dout  (head[g]),
      .full  (full[g]),
      .empty (empty[g]),
      .count (cnt[g])
    );

    // Ack is judged on the pre-push count; a full FIFO still accepts if it pops.
    assign drain[g]    = gnt_vld && (gnt == CH_W'(g));
    assign pop[g]      = ack[g] && !empty[g] && (!vld_p0[g] || drain[g]);
    assign push_ok[g]  = sel_en[g] && (!full[g] || pop[g]);
    assign hold_nxt[g] = pop[g] || (vld_p0[g] && !drain[g]);
    assign cnt_nxt     = cnt[g] + CW'(push_ok[g]) - CW'(pop[g]);
    assign busy_nxt[g] = (cnt_nxt == CW'(DEPTH)) || hold_nxt[g];
  end

  always_comb begin
    logic [CH_W-1:0] idx;
    int              j;
    logic            found;
    gnt   = '0;
    found = 1'b0;
    idx   = '0;
    j     = 0;
    for (int k = 0; k < NUM_SW_INST; k++) begin
      j = int'(rr_ptr) + k;
      if (j >= NUM_SW_INST) j = j - NUM_SW_INST;
      idx = j[CH_W-1:0];
      if (!found && vld_p0[idx]) begin
        found = 1'b1;
        gnt   = idx;
      end
    end
    gnt_vld = found && (!vld_p1 || resp_ready);
  end

  // Stage p0: per-channel hold registers
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_SW_INST; i++) begin
      if (pop[i]) hold_p0[i] <= '{data: rd_data[i*W_WIDTH +: W_WIDTH], op_id: head[i], ch: CH_W'(i)};
    end
  end

  // Stage p1: merged output register, control and sticky errors
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0    <= '0;
      vld_p1    <= 1'b0;
      out_p1    <= '0;
      rr_ptr    <= '0;
      sw_busy   <= '0;
      err_ovf   <= '0;
      err_unexp <= '0;
    end else begin
      vld_p0  <= hold_nxt;
      sw_busy <= busy_nxt;
      if (gnt_vld) begin
        out_p1 <= hold_p0[gnt];
        vld_p1 <= 1'b1;
        rr_ptr <= rr_next(gnt, NUM_SW_INST);
      end else if (resp_ready) begin
        vld_p1 <= 1'b0;
      end
      err_ovf   <= (err_ovf   & ~{NUM_SW_INST{err_clr}}) | (sel_en & ~push_ok);
      err_unexp <= (err_unexp & ~{NUM_SW_INST{err_clr}}) | (ack & ~pop);
    end
  end

  assign resp_valid  = vld_p1;
  assign rd_data_out = out_p1.data;
  assign op_id_out   = out_p1.op_id;
  assign resp_ch     = out_p1.ch;

endmodule

// File: tb/tb_rx_resp_tracker.sv
// Bench for rx_resp_tracker: vector table, directed corner sequences and a
// randomized run checked against a queue-based reference model.
module tb_rx_resp_tracker;
  import rx_pkg::*;

  localparam int N   = 5;
  localparam int W   = 8;
  localparam int OW  = 8;
  localparam int D   = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [N-1:0]     sel_en = '0;
  logic [OW-1:0]    op_id = '0;
  logic [N-1:0]     ack = '0;
  logic [N*W-1:0]   rd_data = '0;
  logic             resp_ready = 1'b1;
  logic             err_clr = 1'b0;
  logic [N-1:0]     sw_busy;
  logic             resp_valid;
  logic [W-1:0]     rd_data_out;
  logic [OW-1:0]    op_id_out;
  logic [CH_W-1:0]  resp_ch;
  logic [N-1:0]     err_ovf;
  logic [N-1:0]     err_unexp;

  rx_resp_tracker #(.NUM_SW_INST(N), .W_WIDTH(W), .OP_W(OW), .DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n), .sel_en(sel_en), .op_id(op_id), .ack(ack),
    .rd_data(rd_data), .resp_ready(resp_ready), .err_clr(err_clr),
    .sw_busy(sw_busy), .resp_valid(resp_valid), .rd_data_out(rd_data_out),
    .op_id_out(op_id_out), .resp_ch(resp_ch), .err_ovf(err_ovf), .err_unexp(err_unexp)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: op queues per channel, optional held response, one output slot.
  int           mq [N][$];
  bit           mhv [N];
  int           mhd [N];
  int           mho [N];
  bit           mov;
  int           mdat, mop, mch, mrr;
  bit [N-1:0]   meo, meu, mbusy;

  function automatic void model_reset();
    for (int c = 0; c < N; c++) begin
      mq[c].delete();
      mhv[c] = 0; mhd[c] = 0; mho[c] = 0;
    end
    mov = 0; mdat = 0; mop = 0; mch = 0; mrr = 0;
    meo = '0; meu = '0; mbusy = '0;
  endfunction

  function automatic void model_step();
    bit found = 0;
    int g = 0;
    bit grant;
    bit [N-1:0] drain = '0, ok = '0, so = '0, su = '0;
    for (int k = 0; k < N; k++) begin
      int c = (mrr + k) % N;
      if (!found && mhv[c]) begin found = 1; g = c; end
    end
    grant = found && (!mov || resp_ready);
    if (grant) drain[g] = 1'b1;
    for (int c = 0; c < N; c++)
      ok[c] = ack[c] && (mq[c].size() > 0) && (!mhv[c] || drain[c]);
    if (grant) begin
      mov = 1; mdat = mhd[g]; mop = mho[g]; mch = g; mrr = (g + 1) % N;
    end else if (resp_ready) begin
      mov = 0;
    end
    for (int c = 0; c < N; c++) begin
      if (drain[c]) mhv[c] = 0;
      if (ok[c]) begin
        mhv[c] = 1;
        mho[c] = mq[c].pop_front();
        mhd[c] = int'(rd_data[c*W +: W]);
      end
      if (sel_en[c]) begin
        if (mq[c].size() < D) mq[c].push_back(int'(op_id));
        else so[c] = 1'b1;
      end
      su[c] = ack[c] && !ok[c];
      mbusy[c] = (mq[c].size() == D) || mhv[c];
    end
    meo = (err_clr ? '0 : meo) | so;
    meu = (err_clr ? '0 : meu) | su;
  endfunction

  task automatic compare_model();
    chk("resp_valid", resp_valid, mov);
    if (mov) begin
      chk("rd_data_out", rd_data_out, mdat);
      chk("op_id_out", op_id_out, mop);
      chk("resp_ch", resp_ch, mch);
    end
    chk("err_ovf", err_ovf, meo);
    chk("err_unexp", err_unexp, meu);
    chk("sw_busy", sw_busy, mbusy);
  endtask

  task automatic drive(input logic [N-1:0] s, input logic [OW-1:0] o, input logic [N-1:0] a,
                       input logic [N*W-1:0] d, input logic r, input logic c);
    sel_en = s; op_id = o; ack = a; rd_data = d; resp_ready = r; err_clr = c;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    compare_model();
  endtask

  typedef struct {
    logic [N-1:0]   sel;
    logic [OW-1:0]  op;
    logic [N-1:0]   ak;
    logic [N*W-1:0] dat;
    logic           rdy;
    logic           clr;
    logic           v;
    logic [OW-1:0]  opo;
    logic [W-1:0]   dato;
    logic [CH_W-1:0] ch;
    logic [N-1:0]   eo;
    logic [N-1:0]   eu;
    logic [N-1:0]   busy;
  } vec_t;

  vec_t tbl [18];
  int   chs [$];
  int   ex_order [3];

  initial begin
    tbl[0]  = '{5'b00100, 8'h3A, 5'b00000, 40'h0,          1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 3'd0, 5'b00000, 5'b00000, 5'b00000};
    tbl[1]  = '{5'b00000, 8'h00, 5'b00000, 40'h0,          1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 3'd0, 5'b00000, 5'b00000, 5'b00000};
    tbl[2]  = '{5'b00000, 8'h00, 5'b00000, 40'h0,          1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 3'd0, 5'b00000, 5'b00000, 5'b00000};
    tbl[3]  = '{5'b00000, 8'h00, 5'b00100, 40'h0000550000, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 3'd0, 5'b00000, 5'b00000, 5'b00100};
    tbl[4]  = '{5'b00000, 8'h00, 5'b00000, 40'h0,          1'b1, 1'b0, 1'b1, 8'h3A, 8'h55, 3'd2, 5'b00000, 5'b00000, 5'b00000};
    tbl[5]  = '{5'b00000, 8'h00, 5'b00000, 40'h0,          1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 3'd0, 5'b00000, 5'b00000, 5'b00000};
    tbl[6]  = '{5'b00000, 8'h00, 5'b00001, 40'h0,          1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 3'd0, 5'b00000, 5'b00001, 5'b00000};
    tbl[7]  = '{5'b00000, 8'h00, 5'b00000, 40'h0,          1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 3'd0, 5'b00000, 5'b00000, 5'b00000};
    tbl[8]  = '{5'b00000, 8'h00, 5'b00001, 40'h0,          1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 3'd0, 5'b00000, 5'b00001, 5'b00000};
    tbl[9]  = '{5'b00000, 8'h00, 5'b00000, 40'h0,          1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 3'd0, 5'b00000, 5'b00000, 5'b00000};
    tbl[10] = '{5'b00001, 8'h11, 5'b00000, 40'h0,          1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 3'd0, 5'b00000, 5'b00000, 5'b00000};
    tbl[11] = '{5'b00001, 8'h22, 5'b00000, 40'h0,          1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 3'd0, 5'b00000, 5'b00000, 5'b00001};
    tbl[12] = '{5'b00001, 8'h33, 5'b00000, 40'h0,          1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 3'd0, 5'b00001, 5'b00000, 5'b00001};
    tbl[13] = '{5'b00000, 8'h00, 5'b00001, 40'h00000000A1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 3'd0, 5'b00001, 5'b00000, 5'b00001};
    tbl[14] = '{5'b00000, 8'h00, 5'b00001, 40'h00000000A2, 1'b1, 1'b0, 1'b1, 8'h11, 8'hA1, 3'd0, 5'b00001, 5'b00000, 5'b00001};
    tbl[15] = '{5'b00000, 8'h00, 5'b00000, 40'h0,          1'b1, 1'b0, 1'b1, 8'h22, 8'hA2, 3'd0, 5'b00001, 5'b00000, 5'b00000};
    tbl[16] = '{5'b00000, 8'h00, 5'b00000, 40'h0,          1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 3'd0, 5'b00001, 5'b00000, 5'b00000};
    tbl[17] = '{5'b00000, 8'h00, 5'b00000, 40'h0,          1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 3'd0, 5'b00000, 5'b00000, 5'b00000};
    ex_order = '{3, 4, 1};

    // Power-on reset
    model_reset();
    #12;
    chk("rst_valid", resp_valid, 0);
    chk("rst_busy", sw_busy, 0);
    chk("rst_errs", {err_ovf, err_unexp}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Vector table: single op, unexpected ack/err_clr, FIFO overflow
    for (int r = 0; r < 18; r++) begin
      drive(tbl[r].sel, tbl[r].op, tbl[r].ak, tbl[r].dat, tbl[r].rdy, tbl[r].clr);
      @(posedge clk);
      model_step();
      #1;
      chk($sformatf("tbl%0d_valid", r), resp_valid, tbl[r].v);
      chk($sformatf("tbl%0d_err_ovf", r), err_ovf, tbl[r].eo);
      chk($sformatf("tbl%0d_err_unexp", r), err_unexp, tbl[r].eu);
      chk($sformatf("tbl%0d_busy", r), sw_busy, tbl[r].busy);
      if (tbl[r].v) begin
        chk($sformatf("tbl%0d_op", r), op_id_out, tbl[r].opo);
        chk($sformatf("tbl%0d_data", r), rd_data_out, tbl[r].dato);
        chk($sformatf("tbl%0d_ch", r), resp_ch, tbl[r].ch);
      end
    end

    // Round-robin order: move pointer to 2, then simultaneous acks on 1, 3, 4
    drive(5'b00010, 8'h01, 5'b00000, 40'h0, 1'b1, 1'b0); cycle();
    drive(5'b00000, 8'h00, 5'b00010, 40'h0000000F00, 1'b1, 1'b0); cycle();
    drive(5'b00000, 8'h00, 5'b00000, 40'h0, 1'b1, 1'b0); cycle();
    cycle();
    drive(5'b11010, 8'h40, 5'b00000, 40'h0, 1'b1, 1'b0); cycle();
    drive(5'b00000, 8'h00, 5'b11010, 40'h6463006100, 1'b1, 1'b0); cycle();
    drive(5'b00000, 8'h00, 5'b00000, 40'h0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      cycle();
      if (resp_valid) chs.push_back(int'(resp_ch));
    end
    for (int i = 0; i < 3; i++)
      chk($sformatf("arb_order%0d", i), (i < chs.size()) ? chs[i] : 99, ex_order[i]);

    // Backpressure: output stalls, holds back up, extra ack on a full hold
    drive(5'b00011, 8'h70, 5'b00000, 40'h0, 1'b1, 1'b0); cycle();
    drive(5'b00011, 8'h71, 5'b00000, 40'h0, 1'b1, 1'b0); cycle();
    drive(5'b00000, 8'h00, 5'b00011, 40'h0000008180, 1'b0, 1'b0); cycle();
    drive(5'b00000, 8'h00, 5'b00000, 40'h0, 1'b0, 1'b0); cycle();
    for (int i = 0; i < 4; i++) begin
      drive(5'b00000, 8'h00, (i == 0) ? 5'b00010 : 5'b00000, 40'h0000009900, 1'b0, 1'b0);
      cycle();
      chk("stall_valid", resp_valid, 1);
      chk("stall_op", op_id_out, 8'h70);
      chk("stall_data", rd_data_out, 8'h80);
      chk("stall_ch", resp_ch, 0);
      chk("stall_busy", sw_busy, 5'b00010);
      chk("stall_unexp", err_unexp, 5'b00010);
    end
    drive(5'b00000, 8'h00, 5'b00000, 40'h0, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) cycle();
    drive(5'b00000, 8'h00, 5'b00000, 40'h0, 1'b1, 1'b1); cycle();

    // Reset with two ops queued on channels 0 and 1
    drive(5'b00011, 8'hA0, 5'b00000, 40'h0, 1'b1, 1'b0); cycle();
    drive(5'b00011, 8'hA1, 5'b00000, 40'h0, 1'b1, 1'b0); cycle();
    drive(5'b00000, 8'h00, 5'b00000, 40'h0, 1'b1, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", resp_valid, 0);
    chk("mid_rst_busy", sw_busy, 0);
    chk("mid_rst_errs", {err_ovf, err_unexp}, 0);
    chk("mid_rst_data", {rd_data_out, op_id_out, resp_ch}, 0);
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    drive(5'b00000, 8'h00, 5'b00001, 40'h0, 1'b1, 1'b0); cycle();
    chk("post_rst_unexp", err_unexp, 5'b00001);
    chk("post_rst_valid", resp_valid, 0);
    drive(5'b00000, 8'h00, 5'b00000, 40'h0, 1'b1, 1'b1); cycle();

    // Randomized traffic against the model
    for (int i = 0; i < 800; i++) begin
      sel_en     = ($urandom_range(0, 2) == 0) ? N'($urandom) : '0;
      op_id      = OW'($urandom);
      ack        = ($urandom_range(0, 1) == 0) ? N'($urandom) : '0;
      rd_data    = (N*W)'({$urandom, $urandom});
      resp_ready = ($urandom_range(0, 3) != 0);
      err_clr    = ($urandom_range(0, 19) == 0);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
